// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the program counter, presents a word index to
// the instruction memory, captures the returned word and hands it to decode
// through a 2-entry FIFO with a valid/ready handshake. Handles redirects
// (branch/jump) by flushing the FIFO, and halts on a faulting fetch until the
// next redirect.
//
// Ports:
//   SYS_clk         rising-edge clock
//   SYS_reset       asynchronous active-low reset
//   imem_addr       word index into instruction memory ({2'b00, pc[31:2]})
//   imem_data       instruction word for imem_addr (combinational from memory)
//   redirect_valid  taken branch/jump: load redirect_pc and flush the FIFO
//   redirect_pc     byte-address redirect target
//   id_valid        FIFO head valid toward decode
//   id_ready        decode accepts the head this cycle
//   id_instr        head instruction (NOP_INSTR when empty)
//   id_pc           head byte PC (last popped PC, or RESET_PC, when empty)
//   id_pc_plus4     id_pc + 4, modulo 2^32
//   id_fault        head entry came from a faulting fetch
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1001,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_fault
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] last_pc_q, last_pc_d;

  // FIFO storage: slot "hd" is always the head, slot "tl" the second entry.
  logic [31:0] hd_pc_q, hd_pc_d;
  logic [31:0] hd_instr_q, hd_instr_d;
  logic        hd_fault_q, hd_fault_d;
  logic [31:0] tl_pc_q, tl_pc_d;
  logic [31:0] tl_instr_q, tl_instr_d;
  logic        tl_fault_q, tl_fault_d;

  logic        fetch_fault;
  logic        pop;
  logic        space;
  logic        push;
  logic [1:0]  remain;
  logic [31:0] new_instr;

  // ---------------------------------------------------------------------------
  // Fetch-side decode
  // ---------------------------------------------------------------------------
  assign imem_addr = {2'b00, pc_q[31:2]};

  // Misaligned or beyond the end of memory. Comparing the word index rather
  // than pc+4 means the check fires before any wrap of the PC matters.
  assign fetch_fault = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= IMEM_WORDS);

  assign new_instr = fetch_fault ? NOP_INSTR : imem_data;

  assign pop   = (count_q != 2'd0) && id_ready;
  assign space = (count_q < 2'd2) || pop;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (redirect_valid) begin
          state_d = StRun;
        end else if (push && fetch_fault) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (redirect_valid) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (fetch enable)
  // ---------------------------------------------------------------------------
  always_comb begin
    push = 1'b0;
    unique case (state_q)
      StRun:   push = !redirect_valid && space;
      StHalt:  push = 1'b0;
      default: push = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC and FIFO next state
  // ---------------------------------------------------------------------------
  assign remain = count_q - {1'b0, pop};

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    last_pc_d  = last_pc_q;
    hd_pc_d    = hd_pc_q;
    hd_instr_d = hd_instr_q;
    hd_fault_d = hd_fault_q;
    tl_pc_d    = tl_pc_q;
    tl_instr_d = tl_instr_q;
    tl_fault_d = tl_fault_q;

    // A pop in a redirect cycle still completes the handshake.
    if (pop) begin
      last_pc_d = hd_pc_q;
    end

    if (redirect_valid) begin
      // Slot contents are left as-is; count == 0 masks them.
      count_d = 2'd0;
      pc_d    = redirect_pc;
    end else begin
      if (pop) begin
        hd_pc_d    = tl_pc_q;
        hd_instr_d = tl_instr_q;
        hd_fault_d = tl_fault_q;
      end
      count_d = remain;
      if (push) begin
        if (remain == 2'd0) begin
          hd_pc_d    = pc_q;
          hd_instr_d = new_instr;
          hd_fault_d = fetch_fault;
        end else begin
          tl_pc_d    = pc_q;
          tl_instr_d = new_instr;
          tl_fault_d = fetch_fault;
        end
        count_d = remain + 2'd1;
        // A faulting fetch leaves the PC on the faulting address.
        if (!fetch_fault) begin
          pc_d = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      last_pc_q  <= RESET_PC;
      hd_pc_q    <= RESET_PC;
      hd_instr_q <= NOP_INSTR;
      hd_fault_q <= 1'b0;
      tl_pc_q    <= RESET_PC;
      tl_instr_q <= NOP_INSTR;
      tl_fault_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      last_pc_q  <= last_pc_d;
      hd_pc_q    <= hd_pc_d;
      hd_instr_q <= hd_instr_d;
      hd_fault_q <= hd_fault_d;
      tl_pc_q    <= tl_pc_d;
      tl_instr_q <= tl_instr_d;
      tl_fault_q <= tl_fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side outputs, all derived from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    id_valid    = (count_q != 2'd0);
    id_instr    = id_valid ? hd_instr_q : NOP_INSTR;
    id_pc       = id_valid ? hd_pc_q : last_pc_q;
    id_fault    = id_valid && hd_fault_q;
    id_pc_plus4 = id_pc + 32'd4;
  end

endmodule
